uart_fifo_wr_arbiter: RTL
=========================

# uart_fifo_wr_arbiter

Round-robin write-port arbiter that shares one UART TX FIFO among N requesters (command decoder, status reporter, loopback, debug). Each requester delivers byte packets. The arbiter locks the FIFO write port to one requester until that packet's last byte, or until a burst limit is reached. Packets from different sources therefore never interleave in the TX stream. It sits directly in front of the TX FIFO write side; the FIFO's read side feeds the UART transmitter unchanged.

## Interface
- `B`, 8: data width; must match the FIFO's `B`.
- `N`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum beats per grant, ≥1. The lock is released after this many beats even without `last`.

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 = reset.
- `req`  in  N  per-requester beat valid.
- `last`  in  N  per-requester end-of-packet flag, qualified by `req`.
- `data`  in  N*B  per-requester byte; requester i occupies bits [i*B +: B].
- `ack`  out  N  one-hot beat accepted this cycle.
- `grant`  out  N  one-hot current owner; all-zero when idle.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_w_data`  out  B  FIFO write data.
- `busy`  out  1  1 while in LOCK.

## Operation
- FSM states:
  - IDLE: `grant`=0.
  - LOCK: `grant`=one-hot owner.
- IDLE → LOCK: taken when any `req` bit is set.
  - The owner is the first requester with `req` set, searching upward with wrap from `rr_ptr`.
  - `beat_cnt` is cleared to 0.
- In LOCK, a beat is accepted when `req[owner] & ~fifo_full`. On an accepted beat:
  - `fifo_wr`=1.
  - `fifo_w_data`=`data[owner]`.
  - `ack[owner]`=1.
  - `beat_cnt` increments.
- LOCK → IDLE: taken on an accepted beat with `last[owner]`=1, or when `beat_cnt`+1 == `MAX_BURST`. On this transition `rr_ptr` ← owner+1 mod N.
- When the owner deasserts `req` mid-packet, the lock is held. No other requester is granted until the owner completes.
- `fifo_full` stalls the transfer. `fifo_wr` is never asserted while `fifo_full`=1; the held beat is not acked.
- Non-owner `req`, `last` and `data` are ignored. Their `ack` stays 0.
- `last` is ignored when the same-index `req` is 0.
- `beat_cnt` width is clog2(`MAX_BURST`+1). It cannot overflow because the limit forces release.
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `beat_cnt` = 0.
  - `grant` = 0, `ack` = 0, `fifo_wr` = 0, `fifo_w_data` = 0, `busy` = 0.
- Reset mid-packet discards the lock immediately. Bytes already written stay in the FIFO, and the requester must restart its packet.

## Timing
- The grant is registered: `req` seen in IDLE at edge k gives `grant`/`busy` high after edge k.
- The first beat can be acked in that same cycle (k+1): one cycle from first request to first write.
- `ack`, `fifo_wr` and `fifo_w_data` are combinational from registered `grant`, live `req`, `last`, `data` and `fifo_full`. Requesters hold `data` and `last` stable until `ack`.
- Sustained throughput is 1 byte/cycle inside a grant.
- On release, IDLE lasts exactly one cycle. Minimum gap between packets is 1 cycle, even for the same requester.
- The state, `rr_ptr` and `beat_cnt` update on the edge ending the accepting cycle.

## Structure
- Package `uart_arb_pkg` holds:
  - the state encoding (IDLE, LOCK);
  - the clog2 helper;
  - the default constants `B`, `N`, `MAX_BURST`.
- Sub-module `rr_pick`: purely combinational. Inputs are N-bit `req` and the `rr_ptr` index. Output is one-hot `winner` plus `any`. It is instantiated once by the arbiter.

## Test plan
- Single requester 1, N=4: packet 0x41,0x42,0x43 with `last` on 0x43. Required response:
  - `grant`=0010 one cycle after `req`;
  - three consecutive `fifo_wr` pulses with data 0x41,0x42,0x43;
  - `busy` low on the following cycle.
- Requesters 0 and 2 request simultaneously from reset (`rr_ptr`=0). Required response:
  - 0 is served first;
  - after 0's `last`, 2 is granted after one idle cycle;
  - `rr_ptr` then equals 3.
- Owner 3 mid-packet while requesters 0 and 1 pulse `req`. Required response: no interleaving — `ack[0]` and `ack[1]` stay 0 until requester 3 acks its `last` byte.
- `fifo_full` held high 5 cycles mid-packet. Required response:
  - no `fifo_wr` and no `ack` during those cycles;
  - the held byte is written on the first cycle after `fifo_full` falls.
- `MAX_BURST`=4, requester 1 sends 6 bytes with `last` only on byte 6, requester 2 waiting. Required response:
  - release after byte 4;
  - requester 2 is granted next;
  - requester 1 resumes afterward with bytes 5 and 6.
- `rst` driven low while LOCK with 2 of 5 bytes written. Required response: `grant`, `busy`, `fifo_wr` and `ack` go to 0 asynchronously, and after release the next grant starts from `rr_ptr`=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX FIFO write-port arbiter.
// Holds the FSM encoding, a clog2 helper and the default parameter values.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEFAULT_B         = 8;
  localparam int DEFAULT_N         = 4;
  localparam int DEFAULT_MAX_BURST = 16;

  // Minimum number of bits needed to encode the values 0 .. value-1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/uart_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or above
// rr_ptr, wrapping around, wins.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  winner,
  output logic          any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/uart_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among N packet
// sources; a grant is held until the owner's last byte or the burst limit.
module uart_fifo_wr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int B         = DEFAULT_B,
  parameter int N         = DEFAULT_N,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [N*B-1:0] data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  input  logic           fifo_full,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic           busy
);

  localparam int PW = clog2(N);
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e    r_state;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_owner;
  logic [CW-1:0] r_beat_cnt;
  logic [N-1:0]  r_grant;
  logic          r_busy;

  logic [N-1:0]  w_winner;
  logic          w_any;
  logic [PW-1:0] w_win_idx;
  logic          w_accept;
  logic          w_release;
  logic [PW-1:0] w_next_ptr;

  rr_pick #(.N(N), .PW(PW)) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner[i]) w_win_idx = PW'(i);
    end
  end

  // Beats flow combinationally so a granted owner moves one byte per cycle.
  assign w_accept   = (r_state == ST_LOCK) && req[r_owner] && !fifo_full;
  assign w_release  = w_accept && (last[r_owner] || (r_beat_cnt == LAST_BEAT));
  assign w_next_ptr = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;

  assign ack         = w_accept ? r_grant : '0;
  assign fifo_wr     = w_accept;
  assign fifo_w_data = w_accept ? data[int'(r_owner)*B +: B] : '0;
  assign grant       = r_grant;
  assign busy        = r_busy;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_LOCK;
            r_owner    <= w_win_idx;
            r_grant    <= w_winner;
            r_busy     <= 1'b1;
            r_beat_cnt <= '0;
          end
        end
        ST_LOCK: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
